// File: rtl/fifo_word_packer_if.sv
// Bundle of FIFO-drain and wide-beat stream signals for fifo_word_packer.
// slave = packer side, master = FIFO/downstream side.
interface fifo_word_packer_if #(
   parameter int WIDTH  = 8,
   parameter int RATIO  = 4,
   parameter int CNTWID = $clog2(RATIO) + 1
);
   // Handshake: a beat transfers on the posedge where out_valid & out_ready;
   // out_valid never drops and out_data/out_count never change until then.
   logic                     fifo_empty;
   logic [WIDTH-1:0]         fifo_data;
   logic                     fifo_pop;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH*RATIO-1:0]   out_data;
   logic [CNTWID-1:0]        out_count;
   logic                     busy;
   logic                     dbg_state;

   modport slave (
      input  fifo_empty, fifo_data, flush, out_ready,
      output fifo_pop, out_valid, out_data, out_count, busy, dbg_state
   );

   modport master (
      output fifo_empty, fifo_data, flush, out_ready,
      input  fifo_pop, out_valid, out_data, out_count, busy, dbg_state
   );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead FIFO and packs RATIO narrow entries (little-endian lanes)
// into one wide beat; flush closes a partial beat early.
module fifo_word_packer #(
   parameter int WIDTH  = 8,
   parameter int RATIO  = 4,
   parameter int CNTWID = $clog2(RATIO) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_word_packer_if.slave    io_bus
);
   localparam int                BW      = WIDTH * RATIO;
   localparam logic [CNTWID-1:0] C_RATIO = CNTWID'(RATIO);

   typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNTWID-1:0] r_cnt, w_cnt_nxt;
   logic [BW-1:0]     r_acc, w_acc_nxt;
   logic              w_pop;
   logic              w_hold;

   assign w_hold = (r_state == S_HOLD);
   // The FIFO has no underflow guard, so pop is gated on empty and on reset.
   assign w_pop  = !rst && !w_hold && !io_bus.fifo_empty && (r_cnt < C_RATIO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_acc   <= w_acc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      case (r_state)
         S_FILL: begin
            if (w_pop) begin
               for (int k = 0; k < RATIO; k++) begin
                  if (r_cnt == CNTWID'(k)) w_acc_nxt[k*WIDTH +: WIDTH] = io_bus.fifo_data;
               end
               w_cnt_nxt = r_cnt + CNTWID'(1);
            end
            // A word popped in the flush cycle still belongs to the flushed beat.
            if ((w_pop && (w_cnt_nxt == C_RATIO)) ||
                (io_bus.flush && ((r_cnt != '0) || w_pop))) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (io_bus.out_ready) begin
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_FILL;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   assign io_bus.fifo_pop  = w_pop;
   assign io_bus.out_valid = w_hold;
   assign io_bus.out_data  = w_hold ? r_acc : '0;
   assign io_bus.out_count = w_hold ? r_cnt : '0;
   assign io_bus.busy      = (r_cnt != '0) || w_hold;
   assign io_bus.dbg_state = r_state;
endmodule
